// File: rtl/id_stage.sv
// id_stage: RV32I instruction-decode stage.
// Decodes the fetched instruction into register indices, a sign-extended
// immediate, an ALU operation and pipeline control flags, and reads the two
// source operands from a 32x32 register file that the WB stage writes back.
// Decode and operand reads are purely combinational from instr; only the
// register file holds state.
module id_stage #(
    parameter int WORD_SIZE = 32,
    parameter int NUM_REGS  = 32,
    parameter int REG_SEL   = 5,
    parameter int ADDR_SIZE = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WORD_SIZE-1:0] instr,
    input  logic                 reg_write,
    input  logic [WORD_SIZE-1:0] rd_data,
    input  logic [REG_SEL-1:0]   rd_select,
    output logic [WORD_SIZE-1:0] immd,
    output logic [WORD_SIZE-1:0] data1,
    output logic [WORD_SIZE-1:0] data2,
    output logic [3:0]           alu_op,
    output logic [REG_SEL-1:0]   rd,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 mem_to_reg,
    output logic                 reg_write_out,
    output logic                 alu_src,
    output logic                 branch,
    output logic                 jump
);

    // Major opcodes
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // Immediate format selector
    localparam logic [2:0] T_R = 3'd0;
    localparam logic [2:0] T_I = 3'd1;
    localparam logic [2:0] T_S = 3'd2;
    localparam logic [2:0] T_B = 3'd3;
    localparam logic [2:0] T_U = 3'd4;
    localparam logic [2:0] T_J = 3'd5;
    localparam logic [2:0] T_X = 3'd6;

    // ALU operation codes
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;
    localparam logic [3:0] ALU_PASS = 4'd10;

    // Instruction fields (opcode/instr_type/rs1/rs2 keep their plain names so
    // benches can probe them hierarchically)
    logic [6:0]         opcode;
    logic [2:0]         instr_type;
    logic [REG_SEL-1:0] rs1;
    logic [REG_SEL-1:0] rs2;
    logic [2:0]         w_funct3;
    logic               w_bit30;
    logic [3:0]         w_arith_op;
    logic               w_unused_addr_size;

    logic [WORD_SIZE-1:0] r_regs [0:NUM_REGS-1];

    assign opcode   = instr[6:0];
    assign rd       = instr[11:7];
    assign w_funct3 = instr[14:12];
    assign rs1      = instr[19:15];
    assign rs2      = instr[24:20];
    assign w_bit30  = instr[30];

    // The memory address width is carried for the pipeline but has no use here
    assign w_unused_addr_size = (ADDR_SIZE > 0) ? 1'b1 : 1'b0;

    // funct3 -> ALU op shared by R-type and I-ALU; SUB only exists for R-type
    always_comb begin
        w_arith_op = ALU_ADD;
        case (w_funct3)
            3'b000:  w_arith_op = ((opcode == OP_R) && w_bit30) ? ALU_SUB : ALU_ADD;
            3'b001:  w_arith_op = ALU_SLL;
            3'b010:  w_arith_op = ALU_SLT;
            3'b011:  w_arith_op = ALU_SLTU;
            3'b100:  w_arith_op = ALU_XOR;
            3'b101:  w_arith_op = w_bit30 ? ALU_SRA : ALU_SRL;
            3'b110:  w_arith_op = ALU_OR;
            3'b111:  w_arith_op = ALU_AND;
            default: w_arith_op = ALU_ADD;
        endcase
    end

    // Main decode: format, ALU op and control flags per opcode
    always_comb begin
        instr_type    = T_X;
        alu_op        = ALU_ADD;
        reg_write_out = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_to_reg    = 1'b0;
        alu_src       = 1'b0;
        branch        = 1'b0;
        jump          = 1'b0;
        case (opcode)
            OP_R: begin
                instr_type    = T_R;
                alu_op        = w_arith_op;
                reg_write_out = 1'b1;
            end
            OP_I_ALU: begin
                instr_type    = T_I;
                alu_op        = w_arith_op;
                reg_write_out = 1'b1;
                alu_src       = 1'b1;
            end
            OP_LOAD: begin
                instr_type    = T_I;
                reg_write_out = 1'b1;
                mem_read      = 1'b1;
                mem_to_reg    = 1'b1;
                alu_src       = 1'b1;
            end
            OP_STORE: begin
                instr_type = T_S;
                mem_write  = 1'b1;
                alu_src    = 1'b1;
            end
            OP_BRANCH: begin
                instr_type = T_B;
                branch     = 1'b1;
                case (w_funct3)
                    3'b000, 3'b001: alu_op = ALU_SUB;
                    3'b100, 3'b101: alu_op = ALU_SLT;
                    3'b110, 3'b111: alu_op = ALU_SLTU;
                    default:        alu_op = ALU_ADD;
                endcase
            end
            OP_JAL: begin
                instr_type    = T_J;
                reg_write_out = 1'b1;
                alu_src       = 1'b1;
                jump          = 1'b1;
            end
            OP_JALR: begin
                instr_type    = T_I;
                reg_write_out = 1'b1;
                alu_src       = 1'b1;
                jump          = 1'b1;
            end
            OP_LUI: begin
                instr_type    = T_U;
                alu_op        = ALU_PASS;
                reg_write_out = 1'b1;
                alu_src       = 1'b1;
            end
            OP_AUIPC: begin
                instr_type    = T_U;
                reg_write_out = 1'b1;
                alu_src       = 1'b1;
            end
            default: begin
                instr_type = T_X;
                alu_op     = ALU_ADD;
            end
        endcase
    end

    // Immediate generation by instruction format
    always_comb begin
        immd = {WORD_SIZE{1'b0}};
        case (instr_type)
            T_I:     immd = {{(WORD_SIZE-12){instr[31]}}, instr[31:20]};
            T_S:     immd = {{(WORD_SIZE-12){instr[31]}}, instr[31:25], instr[11:7]};
            T_B:     immd = {{(WORD_SIZE-13){instr[31]}}, instr[31], instr[7],
                             instr[30:25], instr[11:8], 1'b0};
            T_J:     immd = {{(WORD_SIZE-21){instr[31]}}, instr[31], instr[19:12],
                             instr[20], instr[30:21], 1'b0};
            T_U:     immd = {instr[31:12], {(WORD_SIZE-20){1'b0}}};
            T_R:     immd = {WORD_SIZE{1'b0}};
            default: immd = {WORD_SIZE{1'b0}};
        endcase
    end

    // Register file: synchronous clear, write-back ignores x0
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= {WORD_SIZE{1'b0}};
            end
        end else if (reg_write && (rd_select != {REG_SEL{1'b0}})) begin
            r_regs[rd_select] <= rd_data;
        end else begin
            r_regs <= r_regs;
        end
    end

    // Operand A read with same-cycle write-back forwarding
    always_comb begin
        if (rs1 == {REG_SEL{1'b0}}) begin
            data1 = {WORD_SIZE{1'b0}};
        end else if (reg_write && (rd_select == rs1)) begin
            data1 = rd_data;
        end else begin
            data1 = r_regs[rs1];
        end
    end

    // Operand B read with same-cycle write-back forwarding
    always_comb begin
        if (rs2 == {REG_SEL{1'b0}}) begin
            data2 = {WORD_SIZE{1'b0}};
        end else if (reg_write && (rd_select == rs2)) begin
            data2 = rd_data;
        end else begin
            data2 = r_regs[rs2];
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed vector table, randomized
// instructions against a behavioural decode/register model, and hand-written
// sequences for x0 writes, forwarding and mid-run reset.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        reg_write;
    logic [31:0] rd_data;
    logic [4:0]  rd_select;
    logic [31:0] immd, data1, data2;
    logic [3:0]  alu_op;
    logic [4:0]  rd;
    logic        mem_read, mem_write, mem_to_reg, reg_write_out, alu_src, branch, jump;
    logic [6:0]  ctl;

    always #5 clk = ~clk;

    id_stage dut (
        .clk(clk), .rst(rst), .instr(instr), .reg_write(reg_write),
        .rd_data(rd_data), .rd_select(rd_select), .immd(immd),
        .data1(data1), .data2(data2), .alu_op(alu_op), .rd(rd),
        .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
        .reg_write_out(reg_write_out), .alu_src(alu_src), .branch(branch),
        .jump(jump)
    );

    assign ctl = {reg_write_out, mem_read, mem_write, mem_to_reg, alu_src, branch, jump};

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] m_regs [32];

    typedef struct {
        logic [31:0] ins;
        logic [31:0] immd;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic [6:0]  ctl;
    } vec_t;

    typedef struct {
        logic [31:0] immd;
        logic [3:0]  op;
        logic [6:0]  ctl;
    } dec_t;

    vec_t vt [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference ALU op for the arithmetic funct3 encodings
    function automatic logic [3:0] ref_arith(input logic [2:0] f3, input logic b30, input logic is_r);
        logic [3:0] tbl [8];
        tbl = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd4, 4'd6, 4'd3, 4'd2};
        if (f3 == 3'd0 && is_r && b30) return 4'd1;
        if (f3 == 3'd5 && b30) return 4'd7;
        return tbl[f3];
    endfunction

    // Reference decode written with integer arithmetic for the immediates
    function automatic dec_t ref_decode(input logic [31:0] ins);
        dec_t d;
        int v;
        d.immd = 32'd0; d.op = 4'd0; d.ctl = 7'b0000000;
        v = int'(ins[31:20]);
        if (v >= 2048) v -= 4096;
        case (ins[6:0])
            7'b0110011: begin d.ctl = 7'b1000000; d.op = ref_arith(ins[14:12], ins[30], 1'b1); end
            7'b0010011: begin d.ctl = 7'b1000100; d.op = ref_arith(ins[14:12], ins[30], 1'b0); d.immd = v; end
            7'b0000011: begin d.ctl = 7'b1101100; d.immd = v; end
            7'b1100111: begin d.ctl = 7'b1000101; d.immd = v; end
            7'b0100011: begin
                d.ctl = 7'b0010100;
                v = int'(ins[31:25]) * 32 + int'(ins[11:7]);
                if (v >= 2048) v -= 4096;
                d.immd = v;
            end
            7'b1100011: begin
                d.ctl = 7'b0000010;
                v = int'(ins[31]) * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
                if (v >= 4096) v -= 8192;
                d.immd = v;
                case (ins[14:12])
                    3'd0, 3'd1: d.op = 4'd1;
                    3'd4, 3'd5: d.op = 4'd8;
                    3'd6, 3'd7: d.op = 4'd9;
                    default:    d.op = 4'd0;
                endcase
            end
            7'b1101111: begin
                d.ctl = 7'b1000101;
                v = int'(ins[31]) * 1048576 + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
                if (v >= 1048576) v -= 2097152;
                d.immd = v;
            end
            7'b0110111: begin d.ctl = 7'b1000100; d.op = 4'd10; d.immd = ins & 32'hFFFFF000; end
            7'b0010111: begin d.ctl = 7'b1000100; d.immd = ins & 32'hFFFFF000; end
            default: d.ctl = 7'b0000000;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] ref_read(input logic [4:0] rs);
        if (rs == 5'd0) return 32'd0;
        if (reg_write && rd_select == rs) return rd_data;
        return m_regs[rs];
    endfunction

    // Commit the current inputs to the model, pass the clock edge, settle
    task automatic step();
        if (!rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        end else if (reg_write && rd_select != 5'd0) begin
            m_regs[rd_select] = rd_data;
        end
        @(posedge clk);
        #2;
    endtask

    task automatic check_model(input string tag);
        dec_t d;
        d = ref_decode(instr);
        chk({tag, ".immd"}, immd, d.immd);
        chk({tag, ".alu_op"}, {28'd0, alu_op}, {28'd0, d.op});
        chk({tag, ".ctl"}, {25'd0, ctl}, {25'd0, d.ctl});
        chk({tag, ".rd"}, {27'd0, rd}, {27'd0, instr[11:7]});
        chk({tag, ".data1"}, data1, ref_read(instr[19:15]));
        chk({tag, ".data2"}, data2, ref_read(instr[24:20]));
    endtask

    initial begin
        logic [6:0]  ops [10];
        logic [31:0] r;
        int          wv [5];
        logic [4:0]  wi [5];

        vt[0] = '{32'h00c00713, 32'd12,         32'd0,     32'd0,   4'd0,  5'd14, 7'b1000100};
        vt[1] = '{32'h00ee8c33, 32'd0,          32'd69632, 32'd12,  4'd0,  5'd24, 7'b1000000};
        vt[2] = '{32'h200c2803, 32'd512,        32'd69644, 32'd0,   4'd0,  5'd16, 7'b1101100};
        vt[3] = '{32'hed071e23, 32'hFFFFFEDC,   32'd12,    32'd0,   4'd0,  5'd28, 7'b0010100};
        vt[4] = '{32'h12fc5863, 32'd304,        32'd69644, 32'd134, 4'd8,  5'd16, 7'b0000010};
        vt[5] = '{32'h701010ef, 32'd7936,       32'd0,     32'd0,   4'd0,  5'd1,  7'b1000101};
        vt[6] = '{32'h04321ab7, 32'h04321000,   32'd0,     32'd0,   4'd10, 5'd21, 7'b1000100};
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b0000000};
        wi = '{5'd29, 5'd14, 5'd24, 5'd16, 5'd15};
        wv = '{69632, 12, 69644, 0, 134};
        for (int i = 0; i < 32; i++) m_regs[i] = 32'hDEADBEEF;

        // Reset for one edge
        rst = 1'b0; reg_write = 1'b0; rd_data = 32'd0; rd_select = 5'd0; instr = 32'd0;
        #1;
        step();
        rst = 1'b1;
        instr = 32'h00ee8c33;
        #1;
        chk("reset.data1", data1, 32'd0);
        chk("reset.data2", data2, 32'd0);

        // Load the register file
        for (int i = 0; i < 5; i++) begin
            reg_write = 1'b1; rd_select = wi[i]; rd_data = wv[i];
            step();
        end
        reg_write = 1'b0;

        // Directed vector table
        for (int i = 0; i < 7; i++) begin
            instr = vt[i].ins;
            #1;
            chk($sformatf("vec%0d.immd", i), immd, vt[i].immd);
            chk($sformatf("vec%0d.data1", i), data1, vt[i].d1);
            chk($sformatf("vec%0d.data2", i), data2, vt[i].d2);
            chk($sformatf("vec%0d.alu_op", i), {28'd0, alu_op}, {28'd0, vt[i].op});
            chk($sformatf("vec%0d.rd", i), {27'd0, rd}, {27'd0, vt[i].rd});
            chk($sformatf("vec%0d.ctl", i), {25'd0, ctl}, {25'd0, vt[i].ctl});
            chk($sformatf("vec%0d.opcode", i), {25'd0, dut.opcode}, {25'd0, vt[i].ins[6:0]});
            chk($sformatf("vec%0d.rs1", i), {27'd0, dut.rs1}, {27'd0, vt[i].ins[19:15]});
            step();
        end

        // x0 cannot be written
        instr = 32'h00000013;
        reg_write = 1'b1; rd_select = 5'd0; rd_data = 32'd5;
        #1;
        chk("x0.during_write", data1, 32'd0);
        step();
        reg_write = 1'b0;
        #1;
        chk("x0.after_write", data1, 32'd0);

        // Forwarding of the write-back value in the same cycle
        instr = 32'hed071e23;
        reg_write = 1'b1; rd_select = 5'd14; rd_data = 32'd99;
        #1;
        chk("bypass.data1", data1, 32'd99);
        step();
        reg_write = 1'b0;
        #1;
        chk("bypass.stored", data1, 32'd99);

        // Randomized decode and register traffic
        for (int k = 0; k < 400; k++) begin
            r = $urandom();
            if ($urandom_range(0, 9) == 0) instr = r;
            else instr = {r[31:7], ops[$urandom_range(0, 9)]};
            reg_write = 1'(($urandom_range(0, 1)));
            rd_select = 5'($urandom_range(0, 31));
            rd_data   = $urandom();
            rst       = ($urandom_range(0, 49) == 0) ? 1'b0 : 1'b1;
            #1;
            check_model($sformatf("rnd%0d", k));
            step();
        end
        rst = 1'b1;

        // Mid-run reset clears everything, and a write during reset is dropped
        reg_write = 1'b1; rd_select = 5'd29; rd_data = 32'd1234;
        step();
        instr = 32'h00ee8c33;
        rst = 1'b0; reg_write = 1'b1; rd_select = 5'd29; rd_data = 32'd777;
        step();
        rst = 1'b1; reg_write = 1'b0;
        #1;
        chk("midreset.data1", data1, 32'd0);
        chk("midreset.data2", data2, 32'd0);
        chk("midreset.ctl", {25'd0, ctl}, {25'd0, 7'b1000000});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Instruction-decode stage of the RV32I pipeline.
- Takes the fetched 32-bit instruction and decodes opcode, register fields and immediate.
- Reads operands from an internal 32x32 register file, which is written back from the WB stage.
- Drives ALU/memory/branch control signals toward the execute stage.

Parameters:
WORD_SIZE, 32, data/instruction width
NUM_REGS, 32, register-file depth
REG_SEL, 5, register-index width
ADDR_SIZE, 10, memory address width (reserved; unused internally)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous active-low reset
instr  in  WORD_SIZE  instruction to decode
reg_write  in  1  write-back enable
rd_data  in  WORD_SIZE  write-back data
rd_select  in  REG_SEL  write-back destination index (upper bits ignored if driven wider)
immd  out  WORD_SIZE  decoded, sign-extended immediate
data1  out  WORD_SIZE  register value at rs1 = instr[19:15]
data2  out  WORD_SIZE  register value at rs2 = instr[24:20]
alu_op  out  4  ALU operation code
rd  out  REG_SEL  instr[11:7]
mem_read, mem_write, mem_to_reg, reg_write_out, alu_src, branch, jump  out  1 each  control signals

Behaviour:
- Internal signals named opcode (instr[6:0]), instr_type, rs1, rs2, visible to benches hierarchically.
- Decode, immediate generation and register reads are combinational from instr. All outputs are valid within the same cycle instr changes.
- Register file:
  - Write on rising clk when rst=1 and reg_write=1 and rd_select!=0.
  - x0 always reads 0.
  - Read bypass: if reg_write=1 and rd_select equals a nonzero rs1/rs2, the corresponding data output returns rd_data.
- Reset: while rst=0 at a rising edge, all registers clear to 0 and writes are ignored. Outputs remain combinational functions of instr (with regs 0).
- data1/data2 always reflect the rs1/rs2 fields regardless of format.
- alu_op encoding: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SRA=7, SLT=8, SLTU=9, PASS=10 (pass operand B).
- Immediates:
  - I: sign-extended instr[31:20].
  - S: {instr[31:25], instr[11:7]} sign-extended.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0} sign-extended.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0} sign-extended.
  - U: {instr[31:12], 12'b0}.
  - R and unknown: 0.
- Per opcode, listed as reg_write_out/mem_read/mem_write/mem_to_reg/alu_src/branch/jump:
  - R (0110011): 1/0/0/0/0/0/0. alu_op from funct3/funct7: ADD/SUB, SLL, SLT, SLTU, XOR, SRL/SRA, OR, AND.
  - I-ALU (0010011): 1/0/0/0/1/0/0. Same funct3 mapping; no SUB; SRAI when instr[30]=1.
  - LOAD (0000011): 1/1/0/1/1/0/0, ADD.
  - STORE (0100011): 0/0/1/0/1/0/0, ADD.
  - BRANCH (1100011): 0/0/0/0/0/1/0. BEQ/BNE→SUB; BLT/BGE→SLT; BLTU/BGEU→SLTU.
  - JAL (1101111) and JALR (1100111): 1/0/0/0/1/0/1, ADD.
  - LUI (0110111): 1/0/0/0/1/0/0, PASS.
  - AUIPC (0010111): 1/0/0/0/1/0/0, ADD.
  - Unknown opcode: all controls 0, alu_op ADD, immd 0.

Test Plan:
- Reset low one cycle, then write x29=69632, x14=12, x24=69644, x16=0, x15=134 on consecutive edges. Clear reg_write afterward.
- ADDI 0x00c00713 → data1=0, data2=0, immd=12, ADD, controls 1/0/0/0/1/0/0. ADD 0x00ee8c33 → data1=69632, data2=12, immd=0, ADD, 1/0/0/0/0/0/0.
- LW 0x200c2803 → data1=69644, immd=512, ADD, 1/1/0/1/1/0/0. SH 0xed071e23 → data1=12, data2=0, immd=-292, ADD, 0/0/1/0/1/0/0.
- BGE 0x12fc5863 → data1=69644, data2=134, immd=304, SLT, 0/0/0/0/0/1/0. JAL 0x701010ef → immd=7936, ADD, 1/0/0/0/1/0/1, rd=1.
- LUI 0x04321ab7 → immd=0x04321000, PASS, 1/0/0/0/1/0/0, rd=21.
- Write x0 with 5 then read x0 → 0. Bypass: reg_write=1, rd_select=14, rd_data=99, instr reads x14 → data1=99 same cycle. Mid-run rst=0 edge → all regs read 0.
